// File: rtl/mod_mult_barrett_arbiter.sv
// Round-robin front end sharing one Barrett modular multiplier among NREQ
// requesters, each with its own K/U/Mod context, tagging results by requester.
module mod_mult_barrett_arbiter #(
    parameter int NREQ = 4,
    parameter int TAGW = $clog2(NREQ),
    parameter int LAT  = 12
) (
    input  logic                 iClk,
    input  logic                 iRstN,
    input  logic                 iClr,
    input  logic                 iCfgWe,
    input  logic [TAGW-1:0]      iCfgSel,
    input  logic [6:0]           iCfgK,
    input  logic [127:0]         iCfgU,
    input  logic [63:0]          iCfgMod,
    input  logic [NREQ-1:0]      iReqValid,
    output logic [NREQ-1:0]      oReqReady,
    input  logic [NREQ*64-1:0]   iReqData0,
    input  logic [NREQ*64-1:0]   iReqData1,
    output logic                 oRspValid,
    input  logic                 iRspReady,
    output logic [TAGW-1:0]      oRspTag,
    output logic [63:0]          oRspData,
    output logic                 oMmEn,
    output logic                 oMmClr,
    output logic [6:0]           oMmK,
    output logic [127:0]         oMmU,
    output logic [63:0]          oMmMod,
    output logic [63:0]          oMmData0,
    output logic [63:0]          oMmData1,
    input  logic [63:0]          iMmData
);

    logic [6:0]      cfg_k   [NREQ];
    logic [127:0]    cfg_u   [NREQ];
    logic [63:0]     cfg_mod [NREQ];
    logic [63:0]     cur_mod;
    logic [6:0]      cur_k;
    logic [LAT-1:0]  vld;
    logic [TAGW-1:0] tag_q   [LAT];
    logic [TAGW-1:0] rr;
    logic [TAGW-1:0] g;
    logic [TAGW-1:0] idx;
    logic            found;
    logic            same;
    logic            empty;
    logic            issue;

    always_comb begin
        found = 1'b0;
        g     = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = TAGW'((int'(rr) + i) % NREQ);
            if (!found && iReqValid[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
    end

    assign empty     = ~|vld;
    assign same      = (cfg_mod[g] == cur_mod) && (cfg_k[g] == cur_k);
    assign oRspValid = vld[LAT-1];
    assign oRspTag   = tag_q[LAT-1];
    assign oRspData  = iMmData;
    assign oMmEn     = ~(oRspValid & ~iRspReady);
    assign oMmClr    = iClr;
    // A context mismatch blocks everyone until the pipe drains, so g cannot starve
    assign issue     = found & oMmEn & ~iClr & (empty | same);
    assign oReqReady = issue ? (NREQ'(1) << g) : '0;

    assign oMmK     = cfg_k[g];
    assign oMmU     = cfg_u[g];
    assign oMmMod   = cur_mod;
    assign oMmData0 = iReqData0[64*int'(g) +: 64];
    assign oMmData1 = iReqData1[64*int'(g) +: 64];

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int i = 0; i < NREQ; i++) begin
                cfg_k[i]   <= '0;
                cfg_u[i]   <= '0;
                cfg_mod[i] <= '0;
            end
        end else if (iCfgWe) begin
            cfg_k[iCfgSel]   <= iCfgK;
            cfg_u[iCfgSel]   <= iCfgU;
            cfg_mod[iCfgSel] <= iCfgMod;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cur_mod <= '0;
            cur_k   <= '0;
        end else if (issue) begin
            cur_mod <= cfg_mod[g];
            cur_k   <= cfg_k[g];
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            vld <= '0;
            rr  <= '0;
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
        end else if (iClr) begin
            vld <= '0;
            rr  <= '0;
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
        end else if (oMmEn) begin
            vld <= {vld[LAT-2:0], issue};
            for (int i = LAT - 1; i > 0; i--) tag_q[i] <= tag_q[i-1];
            tag_q[0] <= issue ? g : '0;
            if (issue) rr <= (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
        end
    end

endmodule

// File: tb/tb_mod_mult_barrett_arbiter.sv
// Bench for mod_mult_barrett_arbiter: stub multiplier, queue-based reference
// model of arbitration/latency/results, directed plus randomized traffic.
module tb_mod_mult_barrett_arbiter;

    localparam int NREQ = 4;
    localparam int TAGW = 2;
    localparam int LAT  = 12;

    logic                 iClk = 1'b0;
    logic                 iRstN;
    logic                 iClr;
    logic                 iCfgWe;
    logic [TAGW-1:0]      iCfgSel;
    logic [6:0]           iCfgK;
    logic [127:0]         iCfgU;
    logic [63:0]          iCfgMod;
    logic [NREQ-1:0]      iReqValid;
    logic [NREQ-1:0]      oReqReady;
    logic [NREQ*64-1:0]   iReqData0;
    logic [NREQ*64-1:0]   iReqData1;
    logic                 oRspValid;
    logic                 iRspReady;
    logic [TAGW-1:0]      oRspTag;
    logic [63:0]          oRspData;
    logic                 oMmEn;
    logic                 oMmClr;
    logic [6:0]           oMmK;
    logic [127:0]         oMmU;
    logic [63:0]          oMmMod;
    logic [63:0]          oMmData0;
    logic [63:0]          oMmData1;
    logic [63:0]          iMmData;

    mod_mult_barrett_arbiter #(.NREQ(NREQ), .TAGW(TAGW), .LAT(LAT)) dut (
        .iClk(iClk), .iRstN(iRstN), .iClr(iClr),
        .iCfgWe(iCfgWe), .iCfgSel(iCfgSel), .iCfgK(iCfgK),
        .iCfgU(iCfgU), .iCfgMod(iCfgMod),
        .iReqValid(iReqValid), .oReqReady(oReqReady),
        .iReqData0(iReqData0), .iReqData1(iReqData1),
        .oRspValid(oRspValid), .iRspReady(iRspReady),
        .oRspTag(oRspTag), .oRspData(oRspData),
        .oMmEn(oMmEn), .oMmClr(oMmClr), .oMmK(oMmK), .oMmU(oMmU),
        .oMmMod(oMmMod), .oMmData0(oMmData0), .oMmData1(oMmData1),
        .iMmData(iMmData)
    );

    always #5 iClk = ~iClk;

    // Stub multiplier: operands travel LAT enabled stages, reduced by live iMod
    logic [63:0]  mm_a [LAT];
    logic [63:0]  mm_b [LAT];
    logic [127:0] mm_p;

    always @(posedge iClk or negedge iRstN) begin
        if (!iRstN || oMmClr) begin
            for (int i = 0; i < LAT; i++) begin
                mm_a[i] <= '0;
                mm_b[i] <= '0;
            end
        end else if (oMmEn) begin
            for (int i = LAT - 1; i > 0; i--) begin
                mm_a[i] <= mm_a[i-1];
                mm_b[i] <= mm_b[i-1];
            end
            mm_a[0] <= oMmData0;
            mm_b[0] <= oMmData1;
        end
    end

    always_comb begin
        mm_p    = {64'b0, mm_a[LAT-1]} * {64'b0, mm_b[LAT-1]};
        iMmData = '0;
        if (oMmMod != 0) iMmData = 64'(mm_p % {64'b0, oMmMod});
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string t, input logic [127:0] o,
                       input logic [127:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", t, o, e);
        end
    endtask

    // Reference model: in-flight ops as a queue with age in enabled edges
    typedef struct {
        int          tag;
        logic [63:0] data;
        int          age;
    } ent_t;

    ent_t        mq [$];
    logic [63:0] m_mod [NREQ];
    logic [6:0]  m_k   [NREQ];
    logic [63:0] m_cur_mod;
    logic [6:0]  m_cur_k;
    int          m_rr;
    logic [63:0] last_data [NREQ];

    always @(negedge iClk) begin : mon
        bit              ev, en, fnd, sm, iss;
        int              g, k;
        logic [NREQ-1:0] er;
        logic [63:0]     a, b;
        logic [127:0]    p;
        ent_t            e;
        if (!iRstN) begin
            mq.delete();
            m_rr      = 0;
            m_cur_mod = '0;
            m_cur_k   = '0;
            for (int i = 0; i < NREQ; i++) begin
                m_mod[i] = '0;
                m_k[i]   = '0;
            end
            chk("rst_rsp_valid", oRspValid, 0);
            chk("rst_req_ready", oReqReady, 0);
        end else begin
            ev = mq.size() > 0 && mq[0].age >= LAT - 1;
            en = !(ev && !iRspReady);
            fnd = 0;
            g   = 0;
            for (int i = 0; i < NREQ; i++) begin
                k = (m_rr + i) % NREQ;
                if (!fnd && iReqValid[k]) begin
                    fnd = 1;
                    g   = k;
                end
            end
            sm  = m_mod[g] == m_cur_mod && m_k[g] == m_cur_k;
            iss = fnd && en && !iClr && (mq.size() == 0 || sm);
            er  = iss ? NREQ'(1) << g : '0;
            chk("rsp_valid", oRspValid, ev);
            if (ev) begin
                chk("rsp_tag", oRspTag, mq[0].tag);
                chk("rsp_data", oRspData, mq[0].data);
            end
            chk("mm_en", oMmEn, en);
            chk("mm_clr", oMmClr, iClr);
            chk("req_ready", oReqReady, er);
            if (iClr) begin
                mq.delete();
                m_rr = 0;
            end else if (en) begin
                if (ev && iRspReady) begin
                    last_data[mq[0].tag] = mq[0].data;
                    void'(mq.pop_front());
                end
                foreach (mq[i]) mq[i].age++;
                if (iss) begin
                    a = iReqData0[64*g +: 64];
                    b = iReqData1[64*g +: 64];
                    p = {64'b0, a} * {64'b0, b};
                    e.tag  = g;
                    e.data = 64'(p % {64'b0, m_mod[g]});
                    e.age  = 0;
                    mq.push_back(e);
                    m_cur_mod = m_mod[g];
                    m_cur_k   = m_k[g];
                    m_rr      = (g + 1) % NREQ;
                end
            end
            if (iCfgWe) begin
                m_mod[iCfgSel] = iCfgMod;
                m_k[iCfgSel]   = iCfgK;
            end
        end
    end

    // Requester side: per-requester operand queues honoring valid/ready
    logic [63:0] qa [NREQ][$];
    logic [63:0] qb [NREQ][$];
    bit          rnd_rdy = 0;

    task automatic present();
        for (int i = 0; i < NREQ; i++) begin
            iReqValid[i] = qa[i].size() > 0;
            iReqData0[64*i +: 64] = qa[i].size() > 0 ? qa[i][0] : 64'd0;
            iReqData1[64*i +: 64] = qb[i].size() > 0 ? qb[i][0] : 64'd0;
        end
    endtask

    task automatic tick();
        logic [NREQ-1:0] acc;
        @(negedge iClk);
        acc = oReqReady;
        @(posedge iClk);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (acc[i]) begin
                void'(qa[i].pop_front());
                void'(qb[i].pop_front());
            end
        present();
        if (rnd_rdy) iRspReady = ($urandom % 4) != 0;
    endtask

    task automatic push(input int r, input logic [63:0] a,
                        input logic [63:0] b);
        qa[r].push_back(a);
        qb[r].push_back(b);
        present();
    endtask

    task automatic cfg(input int r, input logic [6:0] k,
                       input logic [127:0] u, input logic [63:0] m);
        iCfgWe  = 1;
        iCfgSel = TAGW'(r);
        iCfgK   = k;
        iCfgU   = u;
        iCfgMod = m;
        tick();
        iCfgWe  = 0;
    endtask

    function automatic bit busy();
        bit any = mq.size() > 0;
        for (int i = 0; i < NREQ; i++)
            if (qa[i].size() > 0) any = 1;
        return any;
    endfunction

    task automatic wait_idle(input string t, input int max);
        int c = 0;
        while (busy() && c < max) begin
            tick();
            c++;
        end
        n_cmp++;
        assert (c < max) else begin
            n_err++;
            $error("FAIL %s: observed timeout after %0d cycles expected idle", t, c);
        end
    endtask

    function automatic logic [63:0] rnd(input logic [63:0] m);
        return {$urandom, $urandom} % m;
    endfunction

    int r_sel;

    initial begin
        iRstN = 0; iClr = 0; iCfgWe = 0; iCfgSel = '0;
        iCfgK = '0; iCfgU = '0; iCfgMod = '0;
        iReqValid = '0; iReqData0 = '0; iReqData1 = '0;
        iRspReady = 1;
        for (int i = 0; i < NREQ; i++) last_data[i] = '0;
        repeat (3) @(posedge iClk);
        #1 iRstN = 1;
        tick();

        // single op: 5*7 mod 17
        cfg(0, 7'd5, 128'd60, 64'd17);
        push(0, 64'd5, 64'd7);
        wait_idle("t1_idle", 40);
        chk("t1_data", last_data[0], 64'd1);

        // two requesters on the same context interleave
        cfg(1, 7'd5, 128'd60, 64'd17);
        for (int j = 0; j < 4; j++) begin
            push(0, rnd(17), rnd(17));
            push(1, rnd(17), rnd(17));
        end
        wait_idle("t2_idle", 60);

        // context switch forces a drain
        cfg(1, 7'd7, 128'd168, 64'd97);
        for (int j = 0; j < 3; j++) push(0, rnd(17), rnd(17));
        push(1, 64'd3, 64'd50);
        push(0, rnd(17), rnd(17));
        wait_idle("t3_idle", 100);
        chk("t3_data", last_data[1], 64'd53);

        // backpressure: hold the response for 3 cycles
        cfg(2, 7'd5, 128'd60, 64'd17);
        for (int j = 0; j < 6; j++) begin
            push(0, rnd(17), rnd(17));
            push(2, rnd(17), rnd(17));
        end
        for (int c = 0; c < 40 && !oRspValid; c++) tick();
        iRspReady = 0;
        repeat (3) tick();
        iRspReady = 1;
        rnd_rdy = 1;
        wait_idle("t4_idle", 200);
        rnd_rdy = 0;
        iRspReady = 1;

        // clear with 5 ops in flight
        for (int j = 0; j < 5; j++) push(0, rnd(17), rnd(17));
        repeat (7) tick();
        iClr = 1;
        tick();
        iClr = 0;
        repeat (15) tick();
        push(0, 64'd4, 64'd9);
        wait_idle("t5_idle", 40);
        chk("t5_data", last_data[0], 64'd2);

        // fairness with all four on one context, then async reset mid-run
        cfg(1, 7'd5, 128'd60, 64'd17);
        cfg(3, 7'd5, 128'd60, 64'd17);
        iClr = 1;
        tick();
        iClr = 0;
        for (int j = 0; j < 2; j++)
            for (int r = 0; r < NREQ; r++) push(r, rnd(17), rnd(17));
        repeat (10) tick();
        iRstN = 0;
        #1;
        chk("arst_rsp_valid", oRspValid, 0);
        chk("arst_req_ready", oReqReady, 0);
        chk("arst_rsp_tag", oRspTag, 0);
        chk("arst_mm_mod", oMmMod, 0);
        chk("arst_mm_k", oMmK, 0);
        chk("arst_mm_u", oMmU, 0);
        for (int r = 0; r < NREQ; r++) begin
            qa[r].delete();
            qb[r].delete();
        end
        present();
        repeat (2) tick();
        iRstN = 1;
        tick();

        // random traffic over two contexts with random backpressure
        for (int r = 0; r < NREQ; r++)
            if ($urandom % 2 == 0) cfg(r, 7'd5, 128'd60, 64'd17);
            else cfg(r, 7'd7, 128'd168, 64'd97);
        rnd_rdy = 1;
        for (int j = 0; j < 24; j++) begin
            r_sel = int'($urandom % NREQ);
            push(r_sel, rnd(17), rnd(17));
            if ($urandom % 2 == 0) tick();
        end
        wait_idle("t7_idle", 1500);
        rnd_rdy = 0;
        iRspReady = 1;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
